// File: rtl/prefetch_pkg.sv
// Shared definitions for the L1D prefetch arbiter.
// Contents:
//   PADDR_BITS, LINE_OFFSET_BITS  physical address and cache line offset widths
//   M_PFR, M_PFW                  prefetch-read / prefetch-write mem_cmd encodings
//   line_addr_t                   cache line number (address without line offset)
//   line_of()                     extracts the line number from a physical address
package prefetch_pkg;
    localparam int PADDR_BITS       = 40;
    localparam int LINE_OFFSET_BITS = 6;
    localparam int LINE_BITS        = PADDR_BITS - LINE_OFFSET_BITS;

    localparam logic [4:0] M_PFR = 5'h2;
    localparam logic [4:0] M_PFW = 5'h3;

    typedef logic [LINE_BITS-1:0] line_addr_t;

    function automatic line_addr_t line_of(input logic [PADDR_BITS-1:0] addr);
        return addr[PADDR_BITS-1:LINE_OFFSET_BITS];
    endfunction
endpackage

// File: rtl/prefetch_filter.sv
// Recent-line filter: a small CAM of recently issued cache lines.
// New lines are written at a FIFO pointer that wraps, so the oldest entry
// is overwritten once the filter is full.
// Ports:
//   clock, reset   clock and asynchronous active-low reset
//   lookup_line    line to test; hit is high when a valid entry matches
//   insert         write insert_line at the FIFO pointer this edge
//   clear          invalidate every entry (takes priority over insert)
module prefetch_filter
    import prefetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  line_addr_t lookup_line,
    output logic       hit,
    input  logic       insert,
    input  line_addr_t insert_line,
    input  logic       clear
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    line_addr_t             lines [DEPTH];
    logic [DEPTH-1:0]       valid;
    logic [PTR_W-1:0]       wptr;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (lines[i] == lookup_line)) begin
                hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            wptr  <= '0;
        end else if (clear) begin
            valid <= '0;
            wptr  <= '0;
        end else if (insert) begin
            valid[wptr] <= 1'b1;
            wptr        <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + 1'b1;
        end
    end

    // Line storage needs no reset: an entry is only looked at once its valid bit is set.
    always_ff @(posedge clock) begin
        if (insert && !clear) begin
            lines[wptr] <= insert_line;
        end
    end
endmodule

// File: rtl/prefetch_arbiter.sv
// Shares the single L1D MSHR prefetch port between NUM_SRC prefetch engines.
// Round-robin pick among valid sources, drop of recently issued lines via a
// recent-line filter, a cap of MAX_INFLIGHT granted-but-not-completed
// prefetches, and a one-entry output buffer held until the MSHR accepts it.
// Handshake: a source request is consumed in any cycle where its
// io_src_ready bit is high (no holding required). The output transfers when
// io_prefetch_valid and io_prefetch_ready are both high on a rising edge;
// the payload stays stable while valid is high and ready is low.
// Ports:
//   clock, reset                 clock, asynchronous active-low reset
//   io_src_valid/ready/addr/cmd  per-source request, consumed strobe, address, mem_cmd
//   io_mshr_avail                MSHR has a free entry (gates io_prefetch_valid)
//   io_prefetch_*                prefetch request toward the MSHR
//   io_prefetch_done             one prefetch completed; returns one credit
//   io_flush                     clear filter and the pending output
//   io_drop_count                saturating count of filtered duplicates
module prefetch_arbiter
    import prefetch_pkg::*;
#(
    parameter int NUM_SRC      = 2,
    parameter int FILTER_DEPTH = 8,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            io_src_valid,
    output logic [NUM_SRC-1:0]            io_src_ready,
    input  logic [NUM_SRC*PADDR_BITS-1:0] io_src_addr,
    input  logic [NUM_SRC*5-1:0]          io_src_cmd,
    input  logic                          io_mshr_avail,
    input  logic                          io_prefetch_ready,
    output logic                          io_prefetch_valid,
    output logic [PADDR_BITS-1:0]         io_prefetch_bits_addr,
    output logic [4:0]                    io_prefetch_bits_uop_mem_cmd,
    input  logic                          io_prefetch_done,
    input  logic                          io_flush,
    output logic [15:0]                   io_drop_count
);
    localparam int PTR_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic             out_valid;
    line_addr_t       out_line;
    logic [4:0]       out_cmd;
    logic [CNT_W-1:0] inflight;
    logic [PTR_W-1:0] rr_ptr;     // index of the last granted source
    logic [15:0]      drop_count;

    logic             fire, slot_free, can_grant, grant, dup, new_grant, filter_hit;
    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    line_addr_t       win_line;
    logic [4:0]       win_cmd;
    logic             done_eff, discard;
    logic [CNT_W-1:0] cnt_a;
    int               idx;

    assign io_prefetch_valid            = out_valid & io_mshr_avail;
    assign io_prefetch_bits_addr        = {out_line, {LINE_OFFSET_BITS{1'b0}}};
    assign io_prefetch_bits_uop_mem_cmd = out_cmd;
    assign io_drop_count                = drop_count;

    assign fire      = io_prefetch_valid & io_prefetch_ready;
    assign slot_free = ~out_valid | fire;
    assign can_grant = slot_free & (inflight < CNT_W'(MAX_INFLIGHT)) & ~io_flush;

    // First valid source after the last granted one, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_SRC;
            if (!win_found && io_src_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end

    assign win_line = line_of(io_src_addr[win_idx*PADDR_BITS +: PADDR_BITS]);
    assign win_cmd  = io_src_cmd[win_idx*5 +: 5];

    prefetch_filter #(
        .DEPTH(FILTER_DEPTH)
    ) u_filter (
        .clock       (clock),
        .reset       (reset),
        .lookup_line (win_line),
        .hit         (filter_hit),
        .insert      (new_grant),
        .insert_line (win_line),
        .clear       (io_flush)
    );

    // The pending output also counts as recently issued, even if it fires now.
    assign dup       = filter_hit | (out_valid & (out_line == win_line));
    assign grant     = can_grant & win_found;
    assign new_grant = grant & ~dup;

    // Gated with reset so every output reads 0 while reset is held.
    always_comb begin
        io_src_ready = '0;
        if (grant && reset) begin
            io_src_ready[win_idx] = 1'b1;
        end
    end

    // Credit bookkeeping: a grant and a completion in the same cycle cancel;
    // a completion at zero is ignored; a flushed, unsent entry returns its credit.
    assign done_eff = io_prefetch_done & (inflight != '0);
    assign discard  = io_flush & out_valid & ~fire;
    always_comb begin
        cnt_a = inflight;
        if (new_grant && !done_eff) begin
            cnt_a = inflight + 1'b1;
        end else if (!new_grant && done_eff) begin
            cnt_a = inflight - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_line   <= '0;
            out_cmd    <= '0;
            inflight   <= '0;
            rr_ptr     <= PTR_W'(NUM_SRC - 1);
            drop_count <= '0;
        end else begin
            inflight <= (discard && cnt_a != '0) ? cnt_a - 1'b1 : cnt_a;

            if (io_flush) begin
                out_valid <= 1'b0;
            end else if (new_grant) begin
                out_valid <= 1'b1;
                out_line  <= win_line;
                out_cmd   <= win_cmd;
            end else if (fire) begin
                out_valid <= 1'b0;
            end

            if (grant) begin
                rr_ptr <= win_idx;
            end
            if (grant && dup && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
endmodule

// File: doc/prefetch_arbiter.md
Name: prefetch_arbiter

Overview:
Shares the single L1D MSHR prefetch port between several prefetch engines, such as the next-line prefetcher and a future stride prefetcher.
- Round-robin arbitration across sources.
- Drops requests to recently issued cache lines using a small recent-line filter.
- Throttles by capping outstanding prefetches.
- Holds the winner in a one-entry output buffer until the MSHR side accepts it.

Parameters:
NUM_SRC, 2, number of prefetch sources (2..4).
FILTER_DEPTH, 8, recent-line filter entries (power of 2).
MAX_INFLIGHT, 4, maximum granted-but-not-completed prefetches (1..15).

Ports:
clock  in  1  single clock for the block.
reset  in  1  asynchronous, active-low reset.
io_src_valid  in  NUM_SRC  per-source request valid.
io_src_ready  out  NUM_SRC  per-source consumed strobe.
io_src_addr  in  NUM_SRC*40  per-source physical address; source i occupies bits [40i+39:40i].
io_src_cmd  in  NUM_SRC*5  per-source mem_cmd (M_PFR or M_PFW).
io_mshr_avail  in  1  MSHR has a free entry.
io_prefetch_ready  in  1  MSHR accepts the prefetch.
io_prefetch_valid  out  1  prefetch request valid.
io_prefetch_bits_addr  out  40  line-aligned prefetch address.
io_prefetch_bits_uop_mem_cmd  out  5  prefetch command.
io_prefetch_done  in  1  one prefetch completed (refill or nack); returns one credit.
io_flush  in  1  fence/sfence: clear filter and pending output.
io_drop_count  out  16  saturating count of filtered duplicates.

Behaviour:
Reset values:
- Reset asserted low, asynchronously.
- Clears out_valid, out_addr, out_cmd, the inflight counter, all filter valid bits, the RR pointer (last-granted = NUM_SRC-1) and io_drop_count.
- All outputs read 0 during reset.

Address handling:
- line(a) = a[39:6].
- Output address = {line, 6'b0}.

Output stage and handshake:
- io_prefetch_valid = out_valid & io_mshr_avail.
- fire = io_prefetch_valid & io_prefetch_ready.
- out_valid clears on fire unless refilled by a grant in the same cycle.

Slot and grant:
- slot_free = ~out_valid | fire.
- can_grant = slot_free & (inflight < MAX_INFLIGHT) & ~io_flush.
- When can_grant is true, the winner is the first valid source after the RR pointer, cyclic.

Ready:
- io_src_ready[winner] = 1 only when can_grant is true.
- All other ready bits are 0.
- Ready does not depend combinationally on io_prefetch_ready beyond fire.

Duplicate handling:
- A request is a duplicate if its line matches any valid filter entry or (out_valid & line(out_addr)).
- A duplicate is still consumed (ready = 1).
- A duplicate does not load the output, does not take a credit, and increments io_drop_count, saturating at 16'hFFFF.

Non-duplicate grant:
- Loads out_addr, out_cmd and out_valid = 1 on the next edge.
- Increments inflight.
- Writes the line into the filter at the FIFO write pointer; the pointer wraps modulo FILTER_DEPTH and overwrites the oldest entry.

RR pointer:
- Updates to the winner on every grant, duplicate or not.
- Unchanged when there is no grant.

Latency:
- Grant at cycle N produces io_prefetch_valid at N+1 (if mshr_avail).
- Back-to-back grants are possible when fire happens in the same cycle.

Inflight credits:
- +1 on a non-duplicate grant, -1 on io_prefetch_done.
- Both in the same cycle: unchanged.
- done at inflight = 0 is ignored (no underflow).
- Counter width is clog2(MAX_INFLIGHT+1).

Flush:
- io_flush (1-cycle pulse) clears filter valid bits and out_valid at the next edge.
- If out_valid was set and not firing that cycle, inflight is decremented for the discarded entry.
- No grants in the flush cycle; a fire in that cycle is still honoured.

Stability:
- io_prefetch_bits_* hold stable while io_prefetch_valid is high and ready is low.
- out_valid persists while io_mshr_avail is low.

Decomposition:
- Shared package prefetch_pkg:
  - PADDR_BITS = 40, LINE_OFFSET_BITS = 6.
  - M_PFR = 5'h2, M_PFW = 5'h3.
  - line_addr_t typedef (34 bits).
- Sub-module prefetch_filter:
  - FILTER_DEPTH-entry CAM of line_addr_t with FIFO insert pointer and clear.
  - Ports: lookup line -> hit; insert strobe + line; clear.

Test Plan:
- Single source, source 0 addr 40'h8000_0040 cmd M_PFR, mshr_avail = 1, ready = 1 -> io_prefetch_valid at next cycle with addr 40'h8000_0040; inflight = 1; io_src_ready[0] high one cycle.
- Both sources valid continuously with distinct lines -> grants alternate 0,1,0,1; inflight saturates at 4; no src_ready until io_prefetch_done pulses, then exactly one more grant per done.
- Source 0 sends 40'h8000_0080 twice, 2 cycles apart, second with offset 0x3F -> second consumed, no output, io_drop_count = 1, inflight unchanged.
- out_valid with io_mshr_avail = 0 for 5 cycles -> io_prefetch_valid = 0 and addr stable; src_ready all 0; on avail = 1 plus ready, fire and a new grant happen in the same cycle.
- Fill filter with 9 distinct lines, then re-request line #1 -> accepted as new (evicted); re-request line #9 -> dropped.
- io_flush with out_valid = 1, inflight = 2 -> next cycle out_valid = 0, inflight = 1, previous duplicate line accepted; reset asserted low mid-transfer -> all outputs 0 immediately, asynchronously.
